pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use hazards, EX-stage branch/jump redirects and MEM-stage trap requests. It also schedules the multi-cycle iterative divider, freezing the front end while a division runs in EX.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/load_use_detect.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32 pipeline hazard control.
package pipe_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        DIV_BUSY = 1'b1
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [4:0]  REG_X0    = 5'd0;

    function automatic logic src_match(input logic use_rs, input logic [4:0] rs, input logic [4:0] rd);
        return use_rs && (rs == rd);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the ID consumer and the EX load.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_memread_i,
    output logic       hazard_o
);

    // x0 never carries a real dependency, so a load into it cannot stall.
    always_comb begin
        hazard_o = 1'b0;
        if (ex_memread_i && (ex_rd_i != REG_X0)) begin
            hazard_o = src_match(id_use_rs1_i, id_rs1_i, ex_rd_i) ||
                       src_match(id_use_rs2_i, id_rs2_i, ex_rd_i);
        end else begin
            hazard_o = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: trap > divider > redirect > load-use > normal flow,
// plus the divider schedule FSM and stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memRead,
    input  logic             ex_is_div,
    input  logic             ex_PCSel,
    input  logic             mem_trapReq,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pc_trap_sel,
    output logic             div_start,
    output logic             div_abort,
    output logic             div_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e           state_q, state_d;
    logic [7:0]       div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             lu_hazard_s;

    load_use_detect u_lud (
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .id_use_rs1_i (id_use_rs1),
        .id_use_rs2_i (id_use_rs2),
        .ex_rd_i      (ex_rd),
        .ex_memread_i (ex_memRead),
        .hazard_o     (lu_hazard_s)
    );

    // Next-state and same-cycle pipeline controls.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_trap_sel = 1'b0;
        div_start   = 1'b0;
        div_abort   = 1'b0;
        div_busy    = 1'b0;
        if (!reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = RUN;
            div_cnt_d   = 8'd0;
        end else if (mem_trapReq) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            pc_trap_sel = 1'b1;
            div_busy    = (state_q == DIV_BUSY);
            div_abort   = (state_q == DIV_BUSY);
            state_d     = RUN;
            div_cnt_d   = 8'd0;
        end else if (state_q == DIV_BUSY) begin
            div_busy = 1'b1;
            if (div_cnt_q != 8'd0) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_flush = 1'b1;
                div_cnt_d   = div_cnt_q - 8'd1;
            end else begin
                // Release cycle: the result lands in EX/MEM; ex_is_div still high is ignored.
                state_d = RUN;
            end
        end else if (ex_is_div) begin
            div_start   = 1'b1;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            div_cnt_d   = 8'(DIV_CYCLES - 1);
            state_d     = DIV_BUSY;
        end else if (ex_PCSel) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu_hazard_s) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else begin
            pc_en = 1'b1;
        end
    end

    // FSM, divider countdown and performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            div_cnt_q   <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            if (!pc_en) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (ifid_flush || idex_flush || exmem_flush) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end else begin
                flush_cnt_q <= flush_cnt_q;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (DIV_CYCLES=4, 4-bit counters).
module tb_pipe_hazard_ctrl;

    localparam int DIVC = 4;
    localparam int CW   = 4;

    // {pc_en, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, exmem_fl, trap_sel, div_start, div_abort, div_busy}
    localparam logic [10:0] NORM   = 11'b1111_000_0000;
    localparam logic [10:0] LU     = 11'b0011_010_0000;
    localparam logic [10:0] REDIR  = 11'b1111_110_0000;
    localparam logic [10:0] DIVST  = 11'b0001_001_0100;
    localparam logic [10:0] DIVBZ  = 11'b0001_001_0001;
    localparam logic [10:0] DIVREL = 11'b1111_000_0001;
    localparam logic [10:0] TRAP   = 11'b1111_111_1000;
    localparam logic [10:0] TRAPBZ = 11'b1111_111_1011;
    localparam logic [10:0] RST    = 11'b0000_111_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
    logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_memRead = 1'b0;
    logic          ex_is_div = 1'b0, ex_PCSel = 1'b0, mem_trapReq = 1'b0;
    logic          pc_en, ifid_en, idex_en, exmem_en;
    logic          ifid_flush, idex_flush, exmem_flush;
    logic          pc_trap_sel, div_start, div_abort, div_busy;
    logic [CW-1:0] stall_cnt, flush_cnt;

    typedef struct {
        logic [10:0]   outs;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } exp_t;

    exp_t          sb_q[$];
    string         tag_q[$];
    int            total = 0;
    int            bad = 0;
    logic [CW-1:0] m_stall = '0;
    logic [CW-1:0] m_flush = '0;

    pipe_hazard_ctrl #(.DIV_CYCLES(DIVC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_is_div(ex_is_div), .ex_PCSel(ex_PCSel),
        .mem_trapReq(mem_trapReq),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .pc_trap_sel(pc_trap_sel), .div_start(div_start), .div_abort(div_abort), .div_busy(div_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [4:0] rd, input logic mr, input logic dv, input logic pcs,
                         input logic tr);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_memRead = mr; ex_is_div = dv; ex_PCSel = pcs; mem_trapReq = tr;
    endtask

    task automatic compare_head();
        exp_t  e;
        string t;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            chk({t, "/outs"}, 32'({pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
                                  exmem_flush, pc_trap_sel, div_start, div_abort, div_busy}), 32'(e.outs));
            chk({t, "/stall_cnt"}, 32'(stall_cnt), 32'(e.stall));
            chk({t, "/flush_cnt"}, 32'(flush_cnt), 32'(e.flush));
        end
        @(posedge clk);
        #1;
    endtask

    // One functional cycle: drive, push expectation, update counter model, check at negedge.
    task automatic cyc(input string tag, input logic [10:0] expo,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic dv, input logic pcs,
                       input logic tr);
        reset = 1'b1;
        drive(rs1, rs2, u1, u2, rd, mr, dv, pcs, tr);
        sb_q.push_back('{outs: expo, stall: m_stall, flush: m_flush});
        tag_q.push_back(tag);
        if (!expo[10]) m_stall = m_stall + 1'b1;
        if (|expo[6:4]) m_flush = m_flush + 1'b1;
        compare_head();
    endtask

    task automatic rst_cyc(input string tag);
        reset = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_stall = '0;
        m_flush = '0;
        sb_q.push_back('{outs: RST, stall: '0, flush: '0});
        tag_q.push_back(tag);
        compare_head();
    endtask

    initial begin
        @(posedge clk);
        #1;
        rst_cyc("reset0");
        rst_cyc("reset1");
        cyc("idle", NORM, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // lw x5 in EX, add x6,x5,x1 in ID; then the load moves on.
        cyc("lu_rs1", LU, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_after", NORM, 5'd5, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_rs2", LU, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_x0", NORM, 5'd0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_nouse", NORM, 5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_noload", NORM, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        // Full division: start at T, busy T+1..T+4, release at T+4.
        cyc("div_T0", DIVST, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < DIVC; i++) begin
            cyc("div_busy", DIVBZ, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        cyc("div_release", DIVREL, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("div_after", NORM, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Trap at the second DIV_BUSY cycle aborts the divider.
        cyc("divtr_T0", DIVST, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("divtr_T1", DIVBZ, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("divtr_trap", TRAPBZ, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("divtr_after", NORM, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Trap in RUN outranks a div entering EX and a redirect.
        cyc("trap_run", TRAP, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc("trap_after", NORM, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Redirect wins over a simultaneous load-use match.
        cyc("redir_lu", REDIR, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("redir_after", NORM, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Reset mid-division, then normal flow.
        cyc("rstdiv_T0", DIVST, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("rstdiv_T1", DIVBZ, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_cyc("rstdiv_reset");
        cyc("rstdiv_norm", NORM, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rstdiv_lu", LU, 5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        // Drive flush_cnt to all-ones, then one more flush wraps it to zero.
        rst_cyc("wrap_reset");
        for (int k = 0; k < (1 << CW) - 1; k++) begin
            cyc("wrap_fill", REDIR, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("wrap_full", 32'(flush_cnt), 32'((1 << CW) - 1));
        cyc("wrap_last", REDIR, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wrap_zero", 32'(flush_cnt), 32'd0);
        cyc("wrap_after", NORM, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
